dsp_i2s_tx: RTL



---
 rtl/dsp_i2s_tx.sv | 100 ++++++++++
 1 files changed

// File: rtl/dsp_i2s_tx.sv
// rtl/dsp_i2s_tx.sv - Philips I2S stereo transmitter with one-deep sample holding register
module dsp_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic        sample_valid,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        frame_start,
    output logic        underrun
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] frame;
    logic [15:0] hold_l;
    logic [15:0] hold_r;
    logic        pending;

    logic        div_wrap;
    logic        fall_event;
    logic        load;
    logic [4:0]  bit_next;
    logic [4:0]  bit_sel;

    // Divider wrap, bclk falling event, next bit position and frame-load decode
    always_comb begin
        div_wrap   = (div_cnt == DIV_LAST);
        fall_event = div_wrap && i2s_bclk;
        bit_next   = bit_cnt + 5'd1;
        // Position k carries F[32-k]; at k = 0 this wraps to F[0], the last bit of the old frame
        bit_sel    = 5'd0 - bit_next;
        load       = fall_event && (bit_cnt == 5'd0);
    end

    // Bit clock divider: toggle bclk every BCLK_DIV system clocks
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + 8'd1;
        end
    end

    // Serialiser: advance bit position, word select and data on each bclk falling event
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            frame     <= '0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
        end else if (fall_event) begin
            bit_cnt   <= bit_next;
            i2s_lrclk <= bit_next[4];
            if (load) begin
                frame     <= {hold_l, hold_r};
                i2s_sdata <= hold_l[15];
            end else begin
                i2s_sdata <= frame[bit_sel];
            end
        end
    end

    // Frame request and stale-data flags, one cycle wide, aligned with the load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load && !pending;
        end
    end

    // Holding register: newest sample wins; a load in the same cycle sees the old contents
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_l  <= '0;
            hold_r  <= '0;
            pending <= 1'b0;
        end else if (sample_valid) begin
            hold_l  <= sample_l;
            hold_r  <= sample_r;
            pending <= 1'b1;
        end else if (load) begin
            pending <= 1'b0;
        end
    end

endmodule
